imem_port_arbiter: RTL and testbench

- Shares the single-port instruction memory between two requesters:
  - the IF-stage fetch requester (read only);
  - the program loader (write, for boot and debug image load).
- Drives the memory address, read-enable, write-enable and write-data inputs, and returns fetch data registered one cycle later.
- Emits a stall to the pipeline whenever a fetch is pending and not granted.
- Sits between the IF stage / loader and the instruction memory.

---
 rtl/imem_pkg.sv | 15 +
 rtl/imem_burst_limiter.sv | 59 +++++
 rtl/imem_port_arbiter.sv | 100 ++++++++++
 tb/tb_imem_port_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory port arbiter slice.
package imem_pkg;

  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned BURST_CNT_W = 4;
  localparam logic [31:0] NOP_WORD    = 32'h0;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

endpackage

// File: rtl/imem_burst_limiter.sv
// Grant decision between fetch and loader, with a saturating counter that
// bounds how long a waiting fetch can be starved by loader writes.
module imem_burst_limiter
  import imem_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  state_e state_i,
  input  logic   fetch_req_i,
  input  logic   ld_req_i,
  output logic   fetch_gnt_o,
  output logic   ld_gnt_o
);

  localparam logic [BURST_CNT_W-1:0] BURST_MAX = BURST_CNT_W'(MAX_BURST);

  logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic                   fetch_gnt, ld_gnt;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    fetch_gnt = 1'b0;
    ld_gnt    = 1'b0;
    // Memory-side enables must read 0 for as long as reset is held.
    if (!rst) begin
      case (state_i)
        RUN: begin
          ld_gnt    = ld_req_i & (~fetch_req_i | (burst_cnt_q < BURST_MAX));
          fetch_gnt = fetch_req_i & ~ld_gnt;
        end
        BOOT, HALT: ld_gnt = ld_req_i;
        default: ;
      endcase
    end
  end

  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (fetch_gnt || !fetch_req_i) begin
      burst_cnt_d = '0;
    end else if (ld_gnt && (burst_cnt_q < BURST_MAX)) begin
      burst_cnt_d = burst_cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) burst_cnt_q <= '0;
    else     burst_cnt_q <= burst_cnt_d;
  end

  assign fetch_gnt_o = fetch_gnt;
  assign ld_gnt_o    = ld_gnt;

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the single-port instruction memory between the IF-stage fetch and
// the program loader; fetch data returns registered one cycle after grant.
module imem_port_arbiter
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              boot_mode,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_misalign,
  output logic              stall,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  state_e            state_q, state_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic [DATA_W-1:0] fetch_data_q, fetch_data_d;
  logic              fetch_misalign_q, fetch_misalign_d;

  imem_burst_limiter #(
    .MAX_BURST (MAX_BURST)
  ) u_burst_limiter (
    .clk         (clk),
    .rst         (rst),
    .state_i     (state_q),
    .fetch_req_i (fetch_req),
    .ld_req_i    (ld_req),
    .fetch_gnt_o (fetch_gnt),
    .ld_gnt_o    (ld_gnt)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    if (!boot_mode) state_d = RUN;
      RUN:     if (boot_mode)  state_d = HALT;
      HALT:    if (!boot_mode) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // Accesses are always word-aligned; low address bits only feed the flag.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (fetch_gnt) begin
      mem_addr = fetch_addr & WORD_MASK;
    end else if (ld_gnt) begin
      mem_addr  = ld_addr & WORD_MASK;
      mem_wdata = ld_wdata;
    end
  end

  assign mem_read  = fetch_gnt;
  assign mem_write = ld_gnt;
  assign stall     = fetch_req & ~fetch_gnt;

  always_comb begin
    fetch_valid_d    = fetch_gnt;
    fetch_misalign_d = fetch_gnt & (fetch_addr[1:0] != 2'b00);
    fetch_data_d     = fetch_gnt ? mem_rdata : fetch_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= BOOT;
      fetch_valid_q    <= 1'b0;
      fetch_data_q     <= DATA_W'(NOP_WORD);
      fetch_misalign_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      fetch_valid_q    <= fetch_valid_d;
      fetch_data_q     <= fetch_data_d;
      fetch_misalign_q <= fetch_misalign_d;
    end
  end

  assign fetch_valid    = fetch_valid_q;
  assign fetch_data     = fetch_data_q;
  assign fetch_misalign = fetch_misalign_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a small word-addressed memory model.
module tb_imem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        boot_mode;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_gnt;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic        fetch_misalign;
  logic        stall;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [31:0] ld_wdata;
  logic        ld_gnt;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .boot_mode      (boot_mode),
    .fetch_req      (fetch_req),
    .fetch_addr     (fetch_addr),
    .fetch_gnt      (fetch_gnt),
    .fetch_valid    (fetch_valid),
    .fetch_data     (fetch_data),
    .fetch_misalign (fetch_misalign),
    .stall          (stall),
    .ld_req         (ld_req),
    .ld_addr        (ld_addr),
    .ld_wdata       (ld_wdata),
    .ld_gnt         (ld_gnt),
    .mem_addr       (mem_addr),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata)
  );

  // Memory model: unwritten words read back as 0xA00000<word index>.
  logic        mem_clr;
  logic [31:0] mem [256];
  logic [255:0] wr_mask;
  logic [7:0]  mem_idx;

  assign mem_idx   = mem_addr[9:2];
  assign mem_rdata = wr_mask[mem_idx] ? mem[mem_idx] : {24'hA00000, mem_idx};

  always @(posedge clk) begin
    if (mem_clr) begin
      wr_mask <= '0;
    end else if (mem_write) begin
      mem[mem_idx]     <= mem_wdata;
      wr_mask[mem_idx] <= 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_clr = 1'b1; boot_mode = 1'b1;
    fetch_req = 1'b0; fetch_addr = '0;
    ld_req = 1'b1; ld_addr = 32'h8; ld_wdata = 32'h55;
    repeat (2) @(posedge clk);
    #2;
    n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%0b exp=0", fetch_valid); end
    n_checks++; if (fetch_data !== 32'h0) begin n_fail++; $display("FAIL rst_data got=%h exp=0", fetch_data); end
    n_checks++; if (fetch_misalign !== 1'b0) begin n_fail++; $display("FAIL rst_misalign got=%0b exp=0", fetch_misalign); end
    n_checks++; if (ld_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_ld_gnt got=%0b exp=0", ld_gnt); end
    n_checks++; if ({mem_read, mem_write} !== 2'b00) begin n_fail++; $display("FAIL rst_mem_en got=%b exp=00", {mem_read, mem_write}); end
    n_checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_mem_bus addr=%h wdata=%h exp=0/0", mem_addr, mem_wdata); end
    tick();
    rst = 1'b0; mem_clr = 1'b0; ld_req = 1'b0;
  endtask

  task automatic test_boot_load();
    tick();
    ld_req = 1'b1; ld_addr = 32'h0; ld_wdata = 32'h0C000004;
    fetch_req = 1'b1; fetch_addr = 32'h0;
    #2;
    n_checks++; if (ld_gnt !== 1'b1) begin n_fail++; $display("FAIL boot_ld_gnt0 got=%0b exp=1", ld_gnt); end
    n_checks++; if (fetch_gnt !== 1'b0 || stall !== 1'b1) begin n_fail++; $display("FAIL boot_stall0 gnt=%0b stall=%0b exp=0/1", fetch_gnt, stall); end
    n_checks++; if (mem_write !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== 32'h0C000004) begin n_fail++; $display("FAIL boot_wr0 we=%0b addr=%h data=%h exp=1/0/0c000004", mem_write, mem_addr, mem_wdata); end
    tick();
    ld_addr = 32'h4; ld_wdata = 32'h8C410004;
    #2;
    n_checks++; if (ld_gnt !== 1'b1) begin n_fail++; $display("FAIL boot_ld_gnt1 got=%0b exp=1", ld_gnt); end
    n_checks++; if (fetch_gnt !== 1'b0 || stall !== 1'b1) begin n_fail++; $display("FAIL boot_stall1 gnt=%0b stall=%0b exp=0/1", fetch_gnt, stall); end
    tick();
    ld_req = 1'b0; boot_mode = 1'b0;
    #2;
    n_checks++; if (fetch_gnt !== 1'b0 || stall !== 1'b1) begin n_fail++; $display("FAIL boot_exit_stall gnt=%0b stall=%0b exp=0/1", fetch_gnt, stall); end
    tick();
    #2;
    n_checks++; if (fetch_gnt !== 1'b1 || mem_read !== 1'b1 || stall !== 1'b0) begin n_fail++; $display("FAIL run_fetch0 gnt=%0b rd=%0b stall=%0b exp=1/1/0", fetch_gnt, mem_read, stall); end
    tick();
    fetch_addr = 32'h4;
    #2;
    n_checks++; if (fetch_valid !== 1'b1 || fetch_data !== 32'h0C000004) begin n_fail++; $display("FAIL boot_data0 valid=%0b data=%h exp=1/0c000004", fetch_valid, fetch_data); end
    n_checks++; if (fetch_gnt !== 1'b1) begin n_fail++; $display("FAIL run_fetch1 got=%0b exp=1", fetch_gnt); end
    tick();
    fetch_req = 1'b0;
    #2;
    n_checks++; if (fetch_valid !== 1'b1 || fetch_data !== 32'h8C410004) begin n_fail++; $display("FAIL boot_data1 valid=%0b data=%h exp=1/8c410004", fetch_valid, fetch_data); end
    tick();
    #2;
    n_checks++; if (fetch_valid !== 1'b0 || fetch_data !== 32'h8C410004) begin n_fail++; $display("FAIL idle_hold valid=%0b data=%h exp=0/8c410004", fetch_valid, fetch_data); end
  endtask

  task automatic test_contention();
    logic exp_ld [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      tick();
      fetch_req = 1'b1; fetch_addr = 32'h20;
      ld_req = 1'b1; ld_addr = 32'h40; ld_wdata = 32'hC0DE0000 + i;
      #2;
      n_checks++; if (ld_gnt !== exp_ld[i] || fetch_gnt !== ~exp_ld[i]) begin n_fail++; $display("FAIL contend_gnt[%0d] ld=%0b f=%0b exp_ld=%0b", i, ld_gnt, fetch_gnt, exp_ld[i]); end
      n_checks++; if (stall !== exp_ld[i]) begin n_fail++; $display("FAIL contend_stall[%0d] got=%0b exp=%0b", i, stall, exp_ld[i]); end
    end
    tick();
    fetch_req = 1'b0; ld_req = 1'b0;
  endtask

  task automatic test_fetch_only();
    logic [31:0] addrs [3] = '{32'h10, 32'h14, 32'h18};
    logic [31:0] words [3] = '{32'hA0000004, 32'hA0000005, 32'hA0000006};
    for (int i = 0; i < 4; i++) begin
      tick();
      fetch_req = (i < 3);
      fetch_addr = (i < 3) ? addrs[i] : 32'h0;
      #2;
      if (i < 3) begin
        n_checks++; if (fetch_gnt !== 1'b1 || stall !== 1'b0 || mem_addr !== addrs[i]) begin n_fail++; $display("FAIL fetch_only_gnt[%0d] gnt=%0b stall=%0b addr=%h exp=1/0/%h", i, fetch_gnt, stall, mem_addr, addrs[i]); end
      end
      if (i > 0) begin
        n_checks++; if (fetch_valid !== 1'b1 || fetch_data !== words[i-1]) begin n_fail++; $display("FAIL fetch_only_data[%0d] valid=%0b data=%h exp=1/%h", i-1, fetch_valid, fetch_data, words[i-1]); end
      end
    end
  endtask

  task automatic test_misalign();
    tick();
    fetch_req = 1'b1; fetch_addr = 32'h12;
    #2;
    n_checks++; if (fetch_gnt !== 1'b1 || mem_addr !== 32'h10) begin n_fail++; $display("FAIL misalign_addr gnt=%0b addr=%h exp=1/10", fetch_gnt, mem_addr); end
    tick();
    fetch_req = 1'b0;
    #2;
    n_checks++; if (fetch_valid !== 1'b1 || fetch_data !== 32'hA0000004 || fetch_misalign !== 1'b1) begin n_fail++; $display("FAIL misalign_resp valid=%0b data=%h mis=%0b exp=1/a0000004/1", fetch_valid, fetch_data, fetch_misalign); end
    tick();
    #2;
    n_checks++; if (fetch_misalign !== 1'b0) begin n_fail++; $display("FAIL misalign_clear got=%0b exp=0", fetch_misalign); end
  endtask

  task automatic test_same_addr();
    tick();
    ld_req = 1'b1; ld_addr = 32'h31; ld_wdata = 32'hDEADBEEF;
    fetch_req = 1'b1; fetch_addr = 32'h30;
    #2;
    n_checks++; if (ld_gnt !== 1'b1 || fetch_gnt !== 1'b0 || mem_addr !== 32'h30) begin n_fail++; $display("FAIL same_addr_gnt ld=%0b f=%0b addr=%h exp=1/0/30", ld_gnt, fetch_gnt, mem_addr); end
    tick();
    ld_req = 1'b0;
    #2;
    n_checks++; if (fetch_gnt !== 1'b1) begin n_fail++; $display("FAIL same_addr_fetch got=%0b exp=1", fetch_gnt); end
    tick();
    fetch_req = 1'b0;
    #2;
    n_checks++; if (fetch_data !== 32'hDEADBEEF || fetch_misalign !== 1'b0) begin n_fail++; $display("FAIL same_addr_data data=%h mis=%0b exp=deadbeef/0", fetch_data, fetch_misalign); end
  endtask

  task automatic test_mid_reset();
    tick();
    fetch_req = 1'b1; fetch_addr = 32'h10;
    #2;
    n_checks++; if (fetch_gnt !== 1'b1) begin n_fail++; $display("FAIL midrst_gnt got=%0b exp=1", fetch_gnt); end
    tick();
    fetch_req = 1'b0;
    #2;
    n_checks++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_valid got=%0b exp=1", fetch_valid); end
    rst = 1'b1;
    #1;
    n_checks++; if (fetch_valid !== 1'b0 || fetch_data !== 32'h0) begin n_fail++; $display("FAIL midrst_async valid=%0b data=%h exp=0/0", fetch_valid, fetch_data); end
    tick();
    rst = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h14;
    #2;
    n_checks++; if (fetch_gnt !== 1'b0 || stall !== 1'b1 || fetch_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_boot gnt=%0b stall=%0b valid=%0b exp=0/1/0", fetch_gnt, stall, fetch_valid); end
    tick();
    #2;
    n_checks++; if (fetch_valid !== 1'b0 || fetch_gnt !== 1'b1) begin n_fail++; $display("FAIL midrst_resume valid=%0b gnt=%0b exp=0/1", fetch_valid, fetch_gnt); end
    tick();
    fetch_req = 1'b0;
    #2;
    n_checks++; if (fetch_valid !== 1'b1 || fetch_data !== 32'hA0000005) begin n_fail++; $display("FAIL midrst_data valid=%0b data=%h exp=1/a0000005", fetch_valid, fetch_data); end
  endtask

  task automatic test_halt();
    tick();
    fetch_req = 1'b1; fetch_addr = 32'h18; boot_mode = 1'b1;
    #2;
    n_checks++; if (fetch_gnt !== 1'b1) begin n_fail++; $display("FAIL halt_edge_gnt got=%0b exp=1", fetch_gnt); end
    tick();
    fetch_addr = 32'h1C; ld_req = 1'b1; ld_addr = 32'h50; ld_wdata = 32'h12345678;
    #2;
    n_checks++; if (fetch_gnt !== 1'b0 || stall !== 1'b1 || ld_gnt !== 1'b1) begin n_fail++; $display("FAIL halt_block f=%0b stall=%0b ld=%0b exp=0/1/1", fetch_gnt, stall, ld_gnt); end
    n_checks++; if (fetch_valid !== 1'b1 || fetch_data !== 32'hA0000006) begin n_fail++; $display("FAIL halt_last_data valid=%0b data=%h exp=1/a0000006", fetch_valid, fetch_data); end
    tick();
    ld_req = 1'b0; boot_mode = 1'b0;
    #2;
    n_checks++; if (fetch_gnt !== 1'b0 || stall !== 1'b1 || fetch_valid !== 1'b0) begin n_fail++; $display("FAIL halt_exit f=%0b stall=%0b valid=%0b exp=0/1/0", fetch_gnt, stall, fetch_valid); end
    tick();
    #2;
    n_checks++; if (fetch_gnt !== 1'b1 || stall !== 1'b0) begin n_fail++; $display("FAIL halt_resume f=%0b stall=%0b exp=1/0", fetch_gnt, stall); end
    tick();
    fetch_addr = 32'h50;
    #2;
    n_checks++; if (fetch_valid !== 1'b1 || fetch_data !== 32'hA0000007) begin n_fail++; $display("FAIL halt_resume_data valid=%0b data=%h exp=1/a0000007", fetch_valid, fetch_data); end
    tick();
    fetch_req = 1'b0;
    #2;
    n_checks++; if (fetch_data !== 32'h12345678) begin n_fail++; $display("FAIL halt_ld_data got=%h exp=12345678", fetch_data); end
  endtask

  initial begin
    test_reset();
    test_boot_load();
    test_contention();
    test_fetch_only();
    test_misalign();
    test_same_addr();
    test_mid_reset();
    test_halt();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
